legv8_encoder: RTL

//  Instruction encoder/loader: inverse of the LEGv8 main decoder. Takes op-class + register/immediate

---
 rtl/legv8_encoder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/legv8_encoder.sv
// LEGv8 instruction encoder/loader: packs op-class requests into 32-bit words, queues them and streams them to imem.
// Optional ENC_ILLEGAL_CNT_EN adds o_illegal_cnt, a saturating count of illegal requests.
module legv8_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [2:0]        i_in_op,
    input  logic              i_in_last,
    input  logic [4:0]        i_in_rd,
    input  logic [4:0]        i_in_rn,
    input  logic [4:0]        i_in_rm,
    input  logic [18:0]       i_in_imm,
    output logic              o_wr_en,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_word_cnt,
    output logic              o_illegal
`ifdef ENC_ILLEGAL_CNT_EN
    ,
    output logic [7:0]        o_illegal_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 r_state, w_state_nx;
    logic [DEPTH-1:0][31:0] r_mem;
    logic [PW:0]            r_wptr, r_rptr;
    logic [31:0]            w_enc;
    logic                   w_legal, w_full, w_empty, w_acc, w_push, w_pop, w_start_go;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_start_go = (r_state == IDLE) && i_start;
    assign o_in_ready = (r_state == RUN) && !w_full;
    assign w_acc      = i_in_valid && o_in_ready;
    assign w_push     = w_acc && w_legal;
    assign o_wr_en    = !w_empty && ((r_state == RUN) || (r_state == DRAIN));
    assign w_pop      = o_wr_en && i_wr_ready;
    assign o_wr_data  = r_mem[r_rptr[PW-1:0]];
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DONE);

    always_comb begin
        w_enc   = '0;
        w_legal = 1'b1;
        case (i_in_op)
            3'd0:    w_enc = {11'b11111000010, i_in_imm[8:0], 2'b00, i_in_rn, i_in_rd};
            3'd1:    w_enc = {11'b11111000000, i_in_imm[8:0], 2'b00, i_in_rn, i_in_rd};
            3'd2:    w_enc = {8'b10110100, i_in_imm, i_in_rd};
            3'd3:    w_enc = {11'b10001011000, i_in_rm, 6'b0, i_in_rn, i_in_rd};
            3'd4:    w_enc = {11'b11001011000, i_in_rm, 6'b0, i_in_rn, i_in_rd};
            3'd5:    w_enc = {11'b10001010000, i_in_rm, 6'b0, i_in_rn, i_in_rd};
            3'd6:    w_enc = {11'b10101010000, i_in_rm, 6'b0, i_in_rn, i_in_rd};
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nx = RUN;
            RUN:     if (w_acc && i_in_last) w_state_nx = DRAIN;
            DRAIN:   if (w_empty) w_state_nx = DONE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[PW-1:0]] <= w_enc;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Address and count advance only on an accepted imem write, so they hold while stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_addr  <= ADDR_W'(BASE_ADDR);
            o_word_cnt <= '0;
        end else if (w_start_go) begin
            o_wr_addr  <= ADDR_W'(BASE_ADDR);
            o_word_cnt <= '0;
        end else if (w_pop) begin
            o_wr_addr  <= o_wr_addr + ADDR_W'(3'd4);
            o_word_cnt <= o_word_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_illegal <= 1'b0;
        else          o_illegal <= w_acc && !w_legal;
    end

`ifdef ENC_ILLEGAL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                    o_illegal_cnt <= '0;
        else if (w_start_go)                             o_illegal_cnt <= '0;
        else if (w_acc && !w_legal && o_illegal_cnt != 8'hFF) o_illegal_cnt <= o_illegal_cnt + 1'b1;
    end
`endif
endmodule
